wptr_ctrl: RTL and testbench

//  Write-domain pointer controller for the async FIFO; parametrised successor of the fixed-depth write handler.

---
 rtl/fifo_pkg.sv | 23 ++
 rtl/fifo_gray2bin.sv | 16 +
 rtl/wptr_ctrl.sv | 88 ++++++++
 tb/tb_wptr_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: Gray/binary conversion and parameter limits.
// Used by both the write-side and read-side pointer controllers.
package fifo_pkg;

  localparam int MIN_ADDR_WIDTH = 2;
  localparam int MAX_ADDR_WIDTH = 16;
  localparam int MAX_PTR_W      = MAX_ADDR_WIDTH + 1;

  // Operate on the widest pointer; callers zero-extend in and truncate out.
  function automatic logic [MAX_PTR_W-1:0] bin2gray(input logic [MAX_PTR_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [MAX_PTR_W-1:0] gray2bin(input logic [MAX_PTR_W-1:0] g);
    logic [MAX_PTR_W-1:0] b;
    b = '0;
    for (int i = 0; i < MAX_PTR_W; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// Combinational Gray-to-binary converter (XOR prefix from the MSB down).
module fifo_gray2bin #(
  parameter int W = 4
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  always_comb begin
    bin = '0;
    for (int i = 0; i < W; i++) begin
      bin[i] = ^(gray >> i);
    end
  end

endmodule

// File: rtl/wptr_ctrl.sv
// Write-domain pointer controller for the async FIFO: pointers, full, level, almost-full.
// Optional sticky overflow flag with `WPTR_OVF_STATUS_EN.
module wptr_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH   = 3,
  parameter int AFULL_THRESH = 6
) (
  input  logic                  wrclk,
  input  logic                  wrst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH:0]   g_rptr_sync,
  output logic [ADDR_WIDTH:0]   b_wptr,
  output logic [ADDR_WIDTH:0]   g_wptr,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic                  wr_accept,
  output logic                  fifo_full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   wr_level
`ifdef WPTR_OVF_STATUS_EN
  ,
  output logic                  wr_overflow
`endif
);

  localparam int AW    = ADDR_WIDTH;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int PTR_W = ADDR_WIDTH + 1;

  if (ADDR_WIDTH < MIN_ADDR_WIDTH || ADDR_WIDTH > MAX_ADDR_WIDTH) begin : g_bad_addr_width
    $error("wptr_ctrl: ADDR_WIDTH out of range 2..16");
  end
  if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_afull_thresh
    $error("wptr_ctrl: AFULL_THRESH out of range 1..DEPTH");
  end

  logic [PTR_W-1:0] rbin;
  logic [PTR_W-1:0] b_wptr_next;
  logic [PTR_W-1:0] g_wptr_next;
  logic [PTR_W-1:0] level_next;
  logic             full_next;
  logic             afull_next;

  fifo_gray2bin #(.W(PTR_W)) u_rptr_g2b (
    .gray (g_rptr_sync),
    .bin  (rbin)
  );

  assign wr_accept = wr_en & ~fifo_full;
  assign waddr     = b_wptr[AW-1:0];

  // Full when the next write pointer equals the read pointer with both wrap bits inverted in Gray.
  always_comb begin
    b_wptr_next = b_wptr + PTR_W'(wr_accept);
    g_wptr_next = PTR_W'(bin2gray(MAX_PTR_W'(b_wptr_next)));
    full_next   = (g_wptr_next == {~g_rptr_sync[AW:AW-1], g_rptr_sync[AW-2:0]});
    level_next  = b_wptr_next - rbin;
    afull_next  = (level_next >= PTR_W'(AFULL_THRESH));
  end

  always_ff @(posedge wrclk or negedge wrst_n) begin
    if (!wrst_n) begin
      b_wptr      <= '0;
      g_wptr      <= '0;
      fifo_full   <= 1'b0;
      almost_full <= 1'b0;
      wr_level    <= '0;
    end else begin
      b_wptr      <= b_wptr_next;
      g_wptr      <= g_wptr_next;
      fifo_full   <= full_next;
      almost_full <= afull_next;
      wr_level    <= level_next;
    end
  end

`ifdef WPTR_OVF_STATUS_EN
  // Sticky until reset: records any write attempt that was dropped because the FIFO was full.
  always_ff @(posedge wrclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wr_overflow <= 1'b0;
    end else if (wr_en && fifo_full) begin
      wr_overflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_wptr_ctrl.sv
// Scoreboard bench for wptr_ctrl (ADDR_WIDTH=3, AFULL_THRESH=6) against a write/read count model.
module tb_wptr_ctrl;

  localparam int AW    = 3;
  localparam int PW    = AW + 1;
  localparam int DEPTH = 8;
  localparam int AF    = 6;

  logic          wrclk = 1'b0;
  logic          wrst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [PW-1:0] g_rptr_sync = '0;
  logic [PW-1:0] b_wptr, g_wptr, wr_level;
  logic [AW-1:0] waddr;
  logic          wr_accept, fifo_full, almost_full;
  logic          ovf_obs;

  wptr_ctrl #(.ADDR_WIDTH(AW), .AFULL_THRESH(AF)) dut (
    .wrclk       (wrclk),
    .wrst_n      (wrst_n),
    .wr_en       (wr_en),
    .g_rptr_sync (g_rptr_sync),
    .b_wptr      (b_wptr),
    .g_wptr      (g_wptr),
    .waddr       (waddr),
    .wr_accept   (wr_accept),
    .fifo_full   (fifo_full),
    .almost_full (almost_full),
    .wr_level    (wr_level)
`ifdef WPTR_OVF_STATUS_EN
    ,
    .wr_overflow (ovf_obs)
`endif
  );

`ifndef WPTR_OVF_STATUS_EN
  assign ovf_obs = 1'b0;
`endif

  always #5 wrclk = ~wrclk;

  typedef struct {
    int acc;
    int b;
    int g;
    int a;
    int full;
    int af;
    int lvl;
    int ovf;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Model: total words written/read since reset; level as last registered.
  int wr_total;
  int rd_total;
  int lvl_m;
  int ovf_m;

  function automatic int to_gray(input int n);
    int m;
    m = n % 16;
    return m ^ (m / 2);
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic resetModel();
    wr_total = 0;
    rd_total = 0;
    lvl_m    = 0;
    ovf_m    = 0;
  endtask

  task automatic applyStimulus(input bit wr, input int rd_new);
    exp_t e;
    int   acc;
    @(posedge wrclk);
    #1;
    rd_total    = rd_new;
    wr_en       = wr;
    g_rptr_sync = PW'(to_gray(rd_total));
    acc         = (wr && lvl_m != DEPTH) ? 1 : 0;
    e.acc  = acc;
    e.b    = wr_total % 16;
    e.g    = to_gray(wr_total);
    e.a    = wr_total % DEPTH;
    e.full = (lvl_m == DEPTH) ? 1 : 0;
    e.af   = (lvl_m >= AF) ? 1 : 0;
    e.lvl  = lvl_m;
`ifdef WPTR_OVF_STATUS_EN
    e.ovf  = ovf_m;
`else
    e.ovf  = 0;
`endif
    sb.push_back(e);
    if (wr && lvl_m == DEPTH) ovf_m = 1;
    wr_total += acc;
    lvl_m = wr_total - rd_total;
  endtask

  // Reset asserted asynchronously between edges; outputs must clear at once.
  task automatic doReset(input string tag);
    @(posedge wrclk);
    #2;
    wrst_n      = 1'b0;
    wr_en       = 1'b0;
    g_rptr_sync = '0;
    #1;
    checkOutput({tag, "_b_wptr"}, int'(b_wptr), 0);
    checkOutput({tag, "_g_wptr"}, int'(g_wptr), 0);
    checkOutput({tag, "_full"}, int'(fifo_full), 0);
    checkOutput({tag, "_afull"}, int'(almost_full), 0);
    checkOutput({tag, "_level"}, int'(wr_level), 0);
    checkOutput({tag, "_ovf"}, int'(ovf_obs), 0);
    resetModel();
    @(negedge wrclk);
    #2;
    wrst_n = 1'b1;
  endtask

  always @(negedge wrclk) begin : monitor
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput("wr_accept", int'(wr_accept), e.acc);
      checkOutput("b_wptr", int'(b_wptr), e.b);
      checkOutput("g_wptr", int'(g_wptr), e.g);
      checkOutput("waddr", int'(waddr), e.a);
      checkOutput("fifo_full", int'(fifo_full), e.full);
      checkOutput("almost_full", int'(almost_full), e.af);
      checkOutput("wr_level", int'(wr_level), e.lvl);
      checkOutput("wr_overflow", int'(ovf_obs), e.ovf);
    end
  end

  initial begin
    resetModel();
    #12 wrst_n = 1'b1;

    // Idle after reset
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 0);

    // Fill to full, then observe the flag
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 0);
    applyStimulus(1'b0, 0);
    #1;
    checkOutput("fill_b_wptr", int'(b_wptr), 8);
    checkOutput("fill_g_wptr", int'(g_wptr), 12);

    // Writes while full are dropped
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 0);
    applyStimulus(1'b0, 0);

    // Read side frees four slots
    applyStimulus(1'b0, 4);
    applyStimulus(1'b0, 4);
    #1;
    checkOutput("drain_level", int'(wr_level), 4);

    // Concurrent write and read advance keep the level; pointers wrap
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 5 + i);
    applyStimulus(1'b0, 12);
    #1;
    checkOutput("wrap_b_wptr", int'(b_wptr), 0);
    checkOutput("wrap_level", int'(wr_level), 4);

    // Randomised traffic with one-step read advances
    for (int i = 0; i < 300; i++) begin
      int rd_next;
      rd_next = rd_total;
      if (($urandom % 3) == 0 && rd_total < wr_total) rd_next = rd_total + 1;
      applyStimulus(1'(($urandom % 4) != 0), rd_next);
    end
    applyStimulus(1'b0, rd_total);

    // Reset in the middle of a fill
    doReset("rst_a");
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 0);
    doReset("rst_mid");
    applyStimulus(1'b1, 0);
    #1;
    checkOutput("post_reset_waddr", int'(waddr), 0);
    applyStimulus(1'b0, 0);

    @(posedge wrclk);
    #1;
    checkOutput("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
